// File: rtl/toggle_bank_pkg.sv
// Shared types and helpers for the toggle/load cell bank.
// Mode encoding matches the cfg_mode field written over the configuration port.
package toggle_bank_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_LOAD   = 2'b01,
      MODE_TOGGLE = 2'b10,
      MODE_DIVIDE = 2'b11
   } mode_t;

   // Channel-select width; a single-channel bank still needs a 1-bit address.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/toggle_bank_if.sv
// Bus bundle between a controller (master) and the toggle bank (slave):
// enable, load data, configuration write port, and the registered cell outputs.
interface toggle_bank_if #(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 8,
   parameter int CH_W     = toggle_bank_pkg::ch_width(CHANNELS)
);
   logic                    en;
   logic [CHANNELS-1:0]     d;
   logic                    cfg_we;
   logic [CH_W-1:0]         cfg_ch;
   toggle_bank_pkg::mode_t  cfg_mode;
   logic [DIV_W-1:0]        cfg_div;
   logic [CHANNELS-1:0]     q;
   logic [CHANNELS-1:0]     tick;

   modport master (
      output en, d, cfg_we, cfg_ch, cfg_mode, cfg_div,
      input  q, tick
   );

   modport slave (
      input  en, d, cfg_we, cfg_ch, cfg_mode, cfg_div,
      output q, tick
   );
endinterface

// File: rtl/toggle_cell.sv
// One channel of the bank: registered toggle/load output with its own mode,
// divide ratio and prescale counter, configured through a decoded write strobe.
module toggle_cell
   import toggle_bank_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             d,
   input  logic             we,
   input  mode_t            wr_mode,
   input  logic [DIV_W-1:0] wr_div,
   output logic             q,
   output logic             tick
);

   mode_t            mode_q, mode_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             tick_q, tick_d;

   always_comb begin
      mode_d = mode_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      q_d    = q_q;
      tick_d = 1'b0;

      if (en) begin
         unique case (mode_q)
            MODE_HOLD: begin
               cnt_d = '0;
            end
            MODE_LOAD: begin
               q_d    = d;
               tick_d = (d != q_q);
               cnt_d  = '0;
            end
            MODE_TOGGLE: begin
               q_d    = ~q_q;
               tick_d = 1'b1;
               cnt_d  = '0;
            end
            MODE_DIVIDE: begin
               if (cnt_q == div_q) begin
                  q_d    = ~q_q;
                  tick_d = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               cnt_d = '0;
            end
         endcase
      end

      // A write restarts the prescaler; the output itself still follows the
      // mode that was active during this cycle.
      if (we) begin
         mode_d = wr_mode;
         div_d  = wr_div;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= MODE_HOLD;
         div_q  <= '0;
         cnt_q  <= '0;
         q_q    <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         q_q    <= q_d;
         tick_q <= tick_d;
      end
   end

   assign q    = q_q;
   assign tick = tick_q;

endmodule

// File: rtl/toggle_bank.sv
// Bank of CHANNELS independent toggle/load cells sharing one enable and one
// configuration write port; the write address is decoded into per-cell strobes.
module toggle_bank
   import toggle_bank_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int DIV_W    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   toggle_bank_if.slave bus
);

   localparam int CH_W = ch_width(CHANNELS);

   logic [CHANNELS-1:0] q_w;
   logic [CHANNELS-1:0] tick_w;
   logic [CHANNELS-1:0] we_w;

   // Out-of-range addresses match no cell, so such writes fall on the floor.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cell
         assign we_w[gi] = bus.cfg_we && (bus.cfg_ch == CH_W'(gi));

         toggle_cell #(
            .DIV_W (DIV_W)
         ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (bus.en),
            .d       (bus.d[gi]),
            .we      (we_w[gi]),
            .wr_mode (bus.cfg_mode),
            .wr_div  (bus.cfg_div),
            .q       (q_w[gi]),
            .tick    (tick_w[gi])
         );
      end
   endgenerate

   assign bus.q    = q_w;
   assign bus.tick = tick_w;

endmodule

// File: tb/tb_toggle_bank.sv
// Directed bench for toggle_bank: a vector table for reset/LOAD/TOGGLE/DIVIDE/enable,
// then hand-written sequences for ignored writes, mid-count rewrites and reset.
module tb_toggle_bank;
   import toggle_bank_pkg::*;

   localparam int CHANNELS = 5;
   localparam int DIV_W    = 8;
   localparam int CH_W     = ch_width(CHANNELS);
   localparam int NVEC     = 27;

   logic clk;
   logic rst_n;

   int checks;
   int failures;

   toggle_bank_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) bus ();

   toggle_bank #(.CHANNELS(CHANNELS), .DIV_W(DIV_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic                rst_n;
      logic                en;
      logic                we;
      logic [CH_W-1:0]     ch;
      mode_t               mode;
      logic [DIV_W-1:0]    div;
      logic [CHANNELS-1:0] d;
      logic [CHANNELS-1:0] exp_q;
      logic [CHANNELS-1:0] exp_tick;
   } vec_t;

   vec_t tbl [NVEC];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.d        = '0;
      bus.cfg_we   = 1'b0;
      bus.cfg_ch   = '0;
      bus.cfg_mode = MODE_HOLD;
      bus.cfg_div  = '0;

      //          rst en we ch  mode         div  d         exp_q     exp_tick
      tbl[0]  = '{0, 1, 1, 0, MODE_TOGGLE, 0, 5'b00000, 5'b00000, 5'b00000};
      tbl[1]  = '{0, 1, 1, 3, MODE_DIVIDE, 0, 5'b00000, 5'b00000, 5'b00000};
      tbl[2]  = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b00000};
      tbl[3]  = '{1, 1, 1, 0, MODE_LOAD,   0, 5'b00000, 5'b00000, 5'b00000};
      tbl[4]  = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b00000};
      tbl[5]  = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00001, 5'b00001, 5'b00001};
      tbl[6]  = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00001, 5'b00001, 5'b00000};
      tbl[7]  = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b00001};
      tbl[8]  = '{1, 0, 1, 1, MODE_TOGGLE, 0, 5'b00000, 5'b00000, 5'b00000};
      tbl[9]  = '{1, 0, 1, 2, MODE_DIVIDE, 0, 5'b00000, 5'b00000, 5'b00000};
      tbl[10] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00110, 5'b00110};
      tbl[11] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b00110};
      tbl[12] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00110, 5'b00110};
      tbl[13] = '{1, 1, 1, 3, MODE_DIVIDE, 3, 5'b00000, 5'b00000, 5'b00110};
      tbl[14] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00110, 5'b00110};
      tbl[15] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b00110};
      tbl[16] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00110, 5'b00110};
      tbl[17] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b01110};
      tbl[18] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01110, 5'b00110};
      tbl[19] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00110};
      tbl[20] = '{1, 0, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00000};
      tbl[21] = '{1, 0, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00000};
      tbl[22] = '{1, 0, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00000};
      tbl[23] = '{1, 0, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00000};
      tbl[24] = '{1, 0, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01000, 5'b00000};
      tbl[25] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b01110, 5'b00110};
      tbl[26] = '{1, 1, 0, 0, MODE_HOLD,   0, 5'b00000, 5'b00000, 5'b01110};

      for (int i = 0; i < NVEC; i++) begin
         rst_n        = tbl[i].rst_n;
         bus.en       = tbl[i].en;
         bus.cfg_we   = tbl[i].we;
         bus.cfg_ch   = tbl[i].ch;
         bus.cfg_mode = tbl[i].mode;
         bus.cfg_div  = tbl[i].div;
         bus.d        = tbl[i].d;
         step();
         chk($sformatf("vec%0d_q", i), 32'(bus.q), 32'(tbl[i].exp_q));
         chk($sformatf("vec%0d_tick", i), 32'(bus.tick), 32'(tbl[i].exp_tick));
         $display("vec %0d: q=%b tick=%b", i, bus.q, bus.tick);
      end
      rst_n      = 1'b1;
      bus.en     = 1'b1;
      bus.cfg_we = 1'b0;
      bus.d      = '0;

      // Write to address CHANNELS must not touch any cell (ch1 keeps toggling, ch3 keeps counting).
      step();
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = CH_W'(CHANNELS);
      bus.cfg_mode = MODE_HOLD;
      bus.cfg_div  = '0;
      step();
      bus.cfg_we = 1'b0;
      chk("ign_a2_q3", 32'(bus.q[3]), 32'd0);
      step();
      chk("ign_a3_q3", 32'(bus.q[3]), 32'd0);
      chk("ign_a3_tick1", 32'(bus.tick[1]), 32'd1);
      step();
      chk("ign_a4_q3", 32'(bus.q[3]), 32'd1);
      chk("ign_a4_tick3", 32'(bus.tick[3]), 32'd1);
      $display("seq ignored-write: q=%b tick=%b", bus.q, bus.tick);

      // Rewrite ch3 to div=1 mid-count: counter restarts, q kept, toggle 2 edges later.
      step();
      bus.cfg_we   = 1'b1;
      bus.cfg_ch   = CH_W'(3);
      bus.cfg_mode = MODE_DIVIDE;
      bus.cfg_div  = DIV_W'(1);
      step();
      bus.cfg_we = 1'b0;
      chk("rw_b2_q3", 32'(bus.q[3]), 32'd1);
      chk("rw_b2_tick3", 32'(bus.tick[3]), 32'd0);
      step();
      chk("rw_b3_q3", 32'(bus.q[3]), 32'd1);
      chk("rw_b3_tick3", 32'(bus.tick[3]), 32'd0);
      step();
      chk("rw_b4_q3", 32'(bus.q[3]), 32'd0);
      chk("rw_b4_tick3", 32'(bus.tick[3]), 32'd1);
      step();
      chk("rw_b5_q3", 32'(bus.q[3]), 32'd0);
      chk("rw_b5_tick3", 32'(bus.tick[3]), 32'd0);
      step();
      chk("rw_b6_q3", 32'(bus.q[3]), 32'd1);
      chk("rw_b6_tick3", 32'(bus.tick[3]), 32'd1);
      $display("seq rewrite-div: q=%b tick=%b", bus.q, bus.tick);

      // One-edge reset mid-DIVIDE: everything to 0 and stays there in HOLD.
      rst_n = 1'b0;
      step();
      chk("rst_q", 32'(bus.q), 32'd0);
      chk("rst_tick", 32'(bus.tick), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("post_rst%0d_q", k), 32'(bus.q), 32'd0);
         chk($sformatf("post_rst%0d_tick", k), 32'(bus.tick), 32'd0);
      end
      $display("seq reset-mid-divide: q=%b tick=%b", bus.q, bus.tick);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/toggle_bank.md
# toggle_bank

Synchronous, parametrised bank of CHANNELS independent single-bit toggle/load cells, each with its own runtime-selected mode and divide ratio. Used as the clocked successor of the lab's combinational toggle/load loop: it replaces the unclocked feedback path with a registered cell, so the toggle behaviour is deterministic and timing-analysable. The bank sits next to the board-level clock/LED logic and provides divided square waves, held levels or loaded data bits per channel.

## Interface
- CHANNELS, 4, number of independent cells (1..32)
- DIV_W, 8, width of the per-channel divide register and prescale counter
- CH_W, $clog2(CHANNELS) (min 1), width of cfg_ch
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  global enable; low freezes every q, counter and tick
- d  in  CHANNELS  per-channel load data
- cfg_we  in  1  configuration write strobe
- cfg_ch  in  CH_W  channel addressed by the write
- cfg_mode  in  2  mode written: 00 HOLD, 01 LOAD, 10 TOGGLE, 11 DIVIDE
- cfg_div  in  DIV_W  divide value written (used in DIVIDE only)
- q  out  CHANNELS  registered cell outputs
- tick  out  CHANNELS  registered one-cycle pulse: 1 in the cycle q[i] has just changed

## Operation
- Per channel registers: q, mode, div, cnt (DIV_W bits), tick.
- Reset (rst_n=0 at a rising edge): q=0, mode=HOLD, div=0, cnt=0, tick=0, all channels. Reset overrides en and cfg_we.
- en=0: q, cnt hold; tick=0; config writes still accepted.
- en=1, per mode:
  - HOLD: q holds; cnt=0.
  - LOAD: q <= d[i]; cnt=0; tick=1 iff d[i] != q.
  - TOGGLE: q <= ~q every cycle; tick=1 every cycle; cnt=0.
  - DIVIDE: if cnt == div then q <= ~q, cnt <= 0, tick=1; else cnt <= cnt+1, tick=0. Half-period = div+1 cycles; div=0 behaves identically to TOGGLE.
- Config write (cfg_we=1, cfg_ch < CHANNELS): mode[cfg_ch] <= cfg_mode, div[cfg_ch] <= cfg_div, cnt[cfg_ch] <= 0. q is not modified by the write.
- cfg_ch >= CHANNELS: write ignored, no state changes.
- Same-cycle write and operation on the addressed channel: q and tick update using the old mode/div; cnt clear from the write takes priority over increment/wrap.
- cnt arithmetic unsigned, DIV_W bits; never exceeds div, so no wrap beyond div occurs. If div is lowered below current cnt, the write's cnt clear makes this impossible.

## Timing
- All outputs registered; no combinational path from any input to q or tick.
- Load latency: d sampled at edge k appears on q after edge k (1 cycle).
- New config takes effect from the first edge after the write edge.
- DIVIDE after a write at edge w: first toggle at edge w+div+1, then every div+1 edges.
- tick is high for exactly one cycle per q transition and coincides with the new q value.
- Reset mid-operation: all outputs at reset values one edge after rst_n sampled low; normal operation resumes at the first edge with rst_n high (channels in HOLD).

## Structure
- Package toggle_bank_pkg: 2-bit mode type and constants MODE_HOLD, MODE_LOAD, MODE_TOGGLE, MODE_DIVIDE.
- Sub-module toggle_cell (one channel: mode/div/cnt/q/tick registers, write-enable input from the bank's decoder); toggle_bank = address decode + generate loop of CHANNELS cells.

## Test plan
- Reset: drive rst_n=0 with en=1, cfg_we=1 -> q=0, tick=0 on every channel; after release all channels hold 0.
- LOAD: ch0 LOAD, d toggled 0,1,1,0 -> q[0] follows one cycle later; tick[0]=1 only on the two changes.
- TOGGLE vs DIVIDE div=0: ch1 TOGGLE, ch2 DIVIDE div=0, written same epoch -> q[1]==q[2] every cycle, period 2.
- DIVIDE div=3: ch3 -> q[3] toggles every 4 cycles (period 8); drop en for 5 cycles mid-count -> phase resumes exactly, no tick while en=0.
- Config corner cases: write with cfg_ch=CHANNELS -> no change; rewrite ch3 div=1 mid-count -> cnt cleared, next toggle 2 edges after write, q not reset.
- Reset mid-DIVIDE: assert rst_n=0 for one edge while ch3 active -> q[3]=0, mode HOLD, no further toggles.
